// File: rtl/dht11_responder.sv
// DHT11 sensor-side emulator: detects a host start pulse, answers with the 80/80 us ack and a 40-bit frame.
// Input path adds 2 cycles of synchronizer latency; no backpressure, dht_in is ignored while the frame is sent.
module dht11_responder #(
  parameter int CICLOS_US       = 50,
  parameter int T_START_US      = 18000,
  parameter int T_RESP_DELAY_US = 30,
  parameter int T_BIT1_HIGH_US  = 70,
  parameter int T_BIT0_HIGH_US  = 27
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dht_in,
  input  logic        habilita,
  input  logic [15:0] umidade_in,
  input  logic [15:0] temperatura_in,
  input  logic        erro_checksum,
  output logic        dht_drive_low,
  output logic        ocupado,
  output logic        fim_resposta,
  output logic [3:0]  db_estado
);

  localparam int T_ACK_US     = 80;
  localparam int T_BIT_LOW_US = 50;
  localparam int T_FIM_LOW_US = 50;
  localparam int PW           = (CICLOS_US > 1) ? $clog2(CICLOS_US) : 1;
  localparam int T_MAX_A      = (T_START_US > T_ACK_US) ? T_START_US : T_ACK_US;
  localparam int T_MAX_B      = (T_BIT1_HIGH_US > T_RESP_DELAY_US) ? T_BIT1_HIGH_US : T_RESP_DELAY_US;
  localparam int T_MAX        = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int UW           = $clog2(T_MAX + 1);

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    MEDE_START = 4'd1,
    DELAY      = 4'd2,
    ACK_LOW    = 4'd3,
    ACK_HIGH   = 4'd4,
    BIT_LOW    = 4'd5,
    BIT_HIGH   = 4'd6,
    FIM_LOW    = 4'd7,
    FIM        = 4'd8
  } estado_t;

  estado_t        estado;
  estado_t        estado_nx;
  logic [1:0]     sync_q;
  logic           line;
  logic           armed;
  logic [PW-1:0]  presc;
  logic           tick;
  logic [UW-1:0]  us_cnt;
  logic [UW-1:0]  dur_m1;
  logic           t_fim;
  logic           start_ok;
  logic [39:0]    shift;
  logic [5:0]     bit_cnt;
  logic           load;
  logic           shift_en;
  logic [7:0]     soma;
  logic [7:0]     checksum;

  assign line      = sync_q[1];
  assign tick      = (presc == PW'(CICLOS_US - 1));
  assign t_fim     = tick && (us_cnt == dur_m1);
  assign start_ok  = (us_cnt >= UW'(T_START_US));
  assign db_estado = estado;

  // 8-bit operands keep the sum modulo 256, which is all the frame carries
  assign soma     = umidade_in[15:8] + umidade_in[7:0] + temperatura_in[15:8] + temperatura_in[7:0];
  assign checksum = soma ^ {7'd0, erro_checksum};

  always_comb begin
    dur_m1 = UW'(T_START_US - 1);
    case (estado)
      DELAY:             dur_m1 = UW'(T_RESP_DELAY_US - 1);
      ACK_LOW, ACK_HIGH: dur_m1 = UW'(T_ACK_US - 1);
      BIT_LOW:           dur_m1 = UW'(T_BIT_LOW_US - 1);
      FIM_LOW:           dur_m1 = UW'(T_FIM_LOW_US - 1);
      BIT_HIGH:          dur_m1 = shift[39] ? UW'(T_BIT1_HIGH_US - 1) : UW'(T_BIT0_HIGH_US - 1);
      default:           dur_m1 = UW'(T_START_US - 1);
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado <= IDLE;
    end else begin
      estado <= estado_nx;
    end
  end

  always_comb begin
    estado_nx = estado;
    load      = 1'b0;
    shift_en  = 1'b0;
    case (estado)
      IDLE: begin
        if (armed && !line && habilita) begin
          estado_nx = MEDE_START;
        end
      end
      MEDE_START: begin
        if (line) begin
          if (start_ok) begin
            estado_nx = DELAY;
            load      = 1'b1;
          end else begin
            estado_nx = IDLE;
          end
        end
      end
      DELAY:    if (t_fim) estado_nx = ACK_LOW;
      ACK_LOW:  if (t_fim) estado_nx = ACK_HIGH;
      ACK_HIGH: if (t_fim) estado_nx = BIT_LOW;
      BIT_LOW:  if (t_fim) estado_nx = BIT_HIGH;
      BIT_HIGH: begin
        if (t_fim) begin
          shift_en  = 1'b1;
          estado_nx = (bit_cnt == 6'd39) ? FIM_LOW : BIT_LOW;
        end
      end
      FIM_LOW:  if (t_fim) estado_nx = FIM;
      FIM:      estado_nx = IDLE;
      default:  estado_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync_q        <= 2'b11;
      armed         <= 1'b0;
      presc         <= '0;
      us_cnt        <= '0;
      shift         <= '0;
      bit_cnt       <= '0;
      dht_drive_low <= 1'b0;
      ocupado       <= 1'b0;
      fim_resposta  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], dht_in};
      // a start needs a high sample seen in IDLE first, so a line already low on IDLE entry never triggers
      armed  <= (estado == IDLE) && line;

      if (estado_nx != estado) begin
        presc  <= '0;
        us_cnt <= '0;
      end else begin
        presc <= tick ? '0 : presc + PW'(1);
        if (tick && (estado != IDLE) && !((estado == MEDE_START) && start_ok)) begin
          us_cnt <= us_cnt + UW'(1);
        end
      end

      if (load) begin
        shift   <= {umidade_in, temperatura_in, checksum};
        bit_cnt <= '0;
      end else if (shift_en) begin
        shift   <= {shift[38:0], 1'b0};
        bit_cnt <= bit_cnt + 6'd1;
      end

      dht_drive_low <= (estado_nx == ACK_LOW) || (estado_nx == BIT_LOW) || (estado_nx == FIM_LOW);
      ocupado       <= (estado_nx != IDLE) && (estado_nx != MEDE_START) && (estado_nx != FIM);
      fim_resposta  <= (estado_nx == FIM);
    end
  end

endmodule

// File: tb/tb_dht11_responder.sv
// Bench for dht11_responder: host line model, frame decoder monitor and expected-frame scoreboard.
module tb_dht11_responder;

  localparam int CIC     = 2;
  localparam int TSTART  = 100;
  localparam int BUDGET  = 20000;

  logic        clock = 1'b0;
  logic        reset;
  logic        dht_in;
  logic        habilita;
  logic [15:0] umidade_in;
  logic [15:0] temperatura_in;
  logic        erro_checksum;
  logic        dht_drive_low;
  logic        ocupado;
  logic        fim_resposta;
  logic [3:0]  db_estado;
  logic        host_low;

  always #5 clock = ~clock;

  // open-drain line with pull-up: low if either side pulls
  assign dht_in = ~(host_low | dht_drive_low);

  dht11_responder #(
    .CICLOS_US (CIC),
    .T_START_US(TSTART)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .dht_in        (dht_in),
    .habilita      (habilita),
    .umidade_in    (umidade_in),
    .temperatura_in(temperatura_in),
    .erro_checksum (erro_checksum),
    .dht_drive_low (dht_drive_low),
    .ocupado       (ocupado),
    .fim_resposta  (fim_resposta),
    .db_estado     (db_estado)
  );

  int errors = 0;
  int checks = 0;
  logic [39:0] exp_q[$];

  int          phase, nbits, run, ack_low, ack_high, bad_low, bad_high;
  int          drive_cnt, ocup_cnt, fim_cnt;
  logic        prev;
  logic [39:0] frame;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_frame();
    phase = 0; nbits = 0; ack_low = 0; ack_high = 0;
    bad_low = 0; bad_high = 0; frame = '0;
  endtask

  task automatic monitor();
    logic [39:0] e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        clear_frame();
        run  = 0;
        prev = 1'b0;
      end else begin
        if (dht_drive_low) drive_cnt++;
        if (ocupado) ocup_cnt++;
        if (dht_drive_low !== prev) begin
          if (prev) begin
            if (phase == 0) begin
              ack_low = run; phase = 1;
            end else if (phase == 2) begin
              if (run != 50 * CIC) bad_low++;
              phase = (nbits == 40) ? 4 : 3;
            end
          end else begin
            if (phase == 0) begin
              check("ocupado_at_ack", {63'd0, ocupado}, 64'd1);
            end else if (phase == 1) begin
              ack_high = run; phase = 2;
            end else if (phase == 3) begin
              if (run == 70 * CIC) frame = {frame[38:0], 1'b1};
              else if (run == 27 * CIC) frame = {frame[38:0], 1'b0};
              else begin
                bad_high++;
                frame = {frame[38:0], 1'b0};
              end
              nbits++;
              phase = 2;
            end
          end
          prev = dht_drive_low;
          run  = 1;
        end else begin
          run++;
        end
        if (fim_resposta) begin
          fim_cnt++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got %0h expected no frame", frame);
          end else begin
            e = exp_q.pop_front();
            check("frame_data", {24'd0, frame}, {24'd0, e});
            check("frame_bits", 64'(nbits), 64'd40);
            check("ack_low_cycles", 64'(ack_low), 64'(80 * CIC));
            check("ack_high_cycles", 64'(ack_high), 64'(80 * CIC));
            check("bit_low_bad", 64'(bad_low), 64'd0);
            check("bit_high_bad", 64'(bad_high), 64'd0);
          end
          clear_frame();
        end
      end
    end
  endtask

  task automatic start_pulse(input int us);
    @(posedge clock); #1;
    host_low = 1'b1;
    repeat (us * CIC) @(posedge clock);
    #1;
    host_low = 1'b0;
  endtask

  task automatic wait_fim(input string name);
    int k;
    k = 0;
    while (!fim_resposta && k < BUDGET) begin
      @(posedge clock); #1;
      k++;
    end
    checks++;
    if (k >= BUDGET) begin
      errors++;
      $display("FAIL %s: got no fim_resposta expected pulse within %0d cycles", name, BUDGET);
    end
    repeat (20) @(posedge clock);
    #1;
  endtask

  task automatic wait_state(input string name, input logic [3:0] s);
    int k;
    k = 0;
    while (db_estado != s && k < BUDGET) begin
      @(posedge clock); #1;
      k++;
    end
    check(name, 64'(db_estado), 64'(s));
  endtask

  task automatic set_data(input logic [15:0] u, input logic [15:0] t, input logic err);
    umidade_in = u; temperatura_in = t; erro_checksum = err;
  endtask

  task automatic stimulus();
    int d0, o0, n;
    logic [3:0] ps;

    reset = 1'b0; habilita = 1'b1; host_low = 1'b0;
    set_data(16'h0000, 16'h0000, 1'b0);
    repeat (5) @(posedge clock);
    #1;
    check("rst_drive", {63'd0, dht_drive_low}, 64'd0);
    check("rst_ocupado", {63'd0, ocupado}, 64'd0);
    check("rst_fim", {63'd0, fim_resposta}, 64'd0);
    check("rst_estado", 64'(db_estado), 64'd0);
    reset = 1'b1;
    repeat (10) @(posedge clock);

    // nominal frame
    set_data(16'h3C00, 16'h1905, 1'b0);
    exp_q.push_back(40'h3C0019055A);
    start_pulse(120);
    wait_fim("fim_nominal");

    // checksum error injection flips bit 0 of the checksum
    set_data(16'h3C00, 16'h1905, 1'b1);
    exp_q.push_back(40'h3C0019055B);
    start_pulse(120);
    wait_fim("fim_cksum_err");

    // short pulse is a glitch
    set_data(16'h3C00, 16'h1905, 1'b0);
    d0 = drive_cnt; o0 = ocup_cnt;
    start_pulse(60);
    repeat (400) @(posedge clock);
    #1;
    check("glitch_drive", 64'(drive_cnt - d0), 64'd0);
    check("glitch_ocupado", 64'(ocup_cnt - o0), 64'd0);
    check("glitch_estado", 64'(db_estado), 64'd0);

    // all-ones data, inputs changed mid-frame
    set_data(16'hFFFF, 16'hFFFF, 1'b0);
    exp_q.push_back(40'hFFFFFFFFFC);
    start_pulse(120);
    wait_state("ff_ack_low", 4'd3);
    set_data(16'h0000, 16'h1234, 1'b1);
    wait_fim("fim_ff");

    // disabled responder ignores a valid start
    habilita = 1'b0;
    d0 = drive_cnt; o0 = ocup_cnt;
    start_pulse(120);
    repeat (600) @(posedge clock);
    #1;
    check("dis_drive", 64'(drive_cnt - d0), 64'd0);
    check("dis_ocupado", 64'(ocup_cnt - o0), 64'd0);
    check("dis_estado", 64'(db_estado), 64'd0);
    habilita = 1'b1;
    repeat (10) @(posedge clock);

    // reset during BIT_LOW of bit 12
    set_data(16'h4B12, 16'h1A07, 1'b0);
    start_pulse(120);
    n = 0; ps = db_estado;
    for (int k = 0; k < BUDGET && n < 13; k++) begin
      @(posedge clock); #1;
      if (db_estado == 4'd5 && ps != 4'd5) n++;
      ps = db_estado;
    end
    check("bit12_reached", 64'(n), 64'd13);
    repeat (5) @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock); #1;
    check("midrst_drive", {63'd0, dht_drive_low}, 64'd0);
    check("midrst_estado", 64'(db_estado), 64'd0);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    repeat (20) @(posedge clock);
    exp_q.push_back(40'h4B121A077E);
    start_pulse(120);
    wait_fim("fim_after_reset");

    // habilita dropped once the ack has started
    set_data(16'h2801, 16'h1703, 1'b0);
    exp_q.push_back(40'h2801170343);
    start_pulse(120);
    wait_state("hab_ack_low", 4'd3);
    habilita = 1'b0;
    wait_fim("fim_hab_drop");
    habilita = 1'b1;

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("fim_count", 64'(fim_cnt), 64'd5);
  endtask

  initial begin
    drive_cnt = 0; ocup_cnt = 0; fim_cnt = 0; run = 0; prev = 1'b0;
    clear_frame();
    reset = 1'b0; habilita = 1'b1; host_low = 1'b0;
    set_data(16'h0000, 16'h0000, 1'b0);
    fork
      monitor();
    join_none
    stimulus();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
